// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: free-running h/v counters on a pixel enable,
// decoded into registered active-low syncs, an active-video flag and line/frame strobes.
module vga_sync_gen #(
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_en,
  output logic [9:0] h_count,
  output logic [9:0] v_count,
  output logic       hsync,
  output logic       vsync,
  output logic       active,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SYNC_END = 10'(H_SYNC);
  localparam logic [9:0] V_SYNC_END = 10'(V_SYNC);
  localparam logic [9:0] H_ACT_LO   = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] H_ACT_HI   = 10'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [9:0] V_ACT_LO   = 10'(V_SYNC + V_BACK);
  localparam logic [9:0] V_ACT_HI   = 10'(V_SYNC + V_BACK + V_ACTIVE);

  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       active_q, active_d;
  logic       line_start_q, line_start_d;
  logic       frame_start_q, frame_start_d;
  logic       h_wrap, v_wrap;

  assign h_wrap = (h_q == H_LAST);
  assign v_wrap = (v_q == V_LAST);

  // Decodes use the next counter values so each output lines up with the count it describes.
  always_comb begin
    h_d           = h_q;
    v_d           = v_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    active_d      = active_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (pix_en) begin
      h_d = h_wrap ? 10'd0 : h_q + 10'd1;
      if (h_wrap) begin
        v_d = v_wrap ? 10'd0 : v_q + 10'd1;
      end
      hsync_d       = (h_d >= H_SYNC_END);
      vsync_d       = (v_d >= V_SYNC_END);
      active_d      = (h_d >= H_ACT_LO) && (h_d < H_ACT_HI) &&
                      (v_d >= V_ACT_LO) && (v_d < V_ACT_HI);
      line_start_d  = h_wrap;
      frame_start_d = h_wrap && v_wrap;
    end
  end

  // Syncs reset inactive even though (0,0) lies inside both sync regions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q           <= '0;
      v_q           <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      active_q      <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      active_q      <= active_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign h_count     = h_q;
  assign v_count     = v_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign active      = active_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule
